mini_src_control_unit: RTL and testbench
========================================

// Module: mini_src_control_unit
// PURPOSE
//  Hardwired Moore sequencer for the Mini SRC CPU; sits directly upstream of datapath and drives all its strobes.
//  Replaces hand-driven testbench T-state sequences: fetch T0-T2, decode IR[31:27], execute T3-T7, repeat.
//  Branch PC write gated by the datapath's CON_out flag.
// PARAMETERS
//  OPW  5  opcode width (IR[31:27]); also width of alu_instruction_bits
// PORTS
//  clk  in  1  system clock, posedge
//  clr  in  1  synchronous active-high reset
//  IR_Data  in  32  instruction register contents
//  CON_out  in  1  branch-condition flag from CON FF
//  Stop  in  1  halt request, sampled in last step of each instruction
//  PC_out/PC_in/IncPC  out  1 each  PC strobes
//  MAR_in/MDR_in/MDR_out/Read/Write  out  1 each  memory-path strobes
//  IR_in/Y_in/Z_in/Zlow_out/Zhigh_out  out  1 each  IR/ALU-register strobes
//  HI_in/HI_out/LO_in/LO_out  out  1 each  HI/LO strobes
//  InPort_out/OutPort_in/C_out  out  1 each  I/O and sign-extended constant strobes
//  Gra/Grb/Grc/Rin/Rout/BAout/CON_in  out  1 each  select-encode and CON load
//  alu_instruction_bits  out  5  ALU op code
//  Run  out  1  high while executing; low in RST/HALT
// BEHAVIOUR
//  - One state per clock. States: RST, T0..T7, HALT. Outputs are a pure decode of state + latched opcode (Moore); only exception is br T6 PC_in=CON_out.
//  - clr high at any posedge → RST; all outputs 0 (incl. Run) in RST. First edge with clr low → T0. Reset mid-instruction abandons it.
//  - Fetch: T0 PC_out MAR_in IncPC Z_in; T1 Zlow_out PC_in Read MDR_in; T2 MDR_out IR_in. Opcode latched from IR_Data in T3; unlisted step = all 0.
//  - Address/add ops use alu_instruction_bits=00011; reg ALU ops use opcode value itself.
//  - reg ALU (00011-01011): T3 Grb Rout Y_in; T4 Grc Rout alu=op Z_in; T5 Zlow_out Gra Rin.
//  - addi/andi/ori: T3 Grb Rout Y_in; T4 C_out alu=00011/00101/00110 Z_in; T5 Zlow_out Gra Rin.
//  - neg/not: T3 Grb Rout alu=op Z_in; T4 Zlow_out Gra Rin.
//  - ldi: T3 Grb BAout Y_in; T4 C_out alu=00011 Z_in; T5 Zlow_out Gra Rin.
//  - ld: as ldi T3-T4; T5 Zlow_out MAR_in; T6 Read MDR_in; T7 MDR_out Gra Rin.
//  - st: as ld T3-T5; T6 Gra Rout MDR_in (Read=0); T7 Write.
//  - br: T3 Gra Rout CON_in; T4 PC_out Y_in; T5 C_out alu=00011 Z_in; T6 Zlow_out, PC_in=CON_out.
//  - jr: T3 Gra Rout PC_in. jal: T3 PC_out Grb Rin (Rb field = R15); T4 Gra Rout PC_in.
//  - in: T3 InPort_out Gra Rin. out: T3 Gra Rout OutPort_in. mflo/mfhi: T3 LO_out/HI_out Gra Rin.
//  - nop and undefined opcodes (11100-11111): T2 → T0.
//  - halt (11011): T2 → HALT; HALT holds all outputs 0, Run=0, until clr.
//  - Last step of any instruction: Stop=1 → HALT, else → T0.
//  - Never assert two bus drivers (PC_out, Zlow_out, Zhigh_out, MDR_out, Rout, BAout, HI_out, LO_out, InPort_out, C_out) in one state.
// CONFIGURATION
//  - CU_MULDIV_EN defined: mul/div (10000/01111): T3 Gra Rout Y_in; T4 Grb Rout alu=op Z_in; T5 Zlow_out LO_in; T6 Zhigh_out HI_in.
//  - CU_MULDIV_EN undefined: mul/div decode as nop (T2 → T0); HI_in/LO_in never asserted.
// TESTING
//  - clr high 2 cycles → all outputs 0, Run=0; first state after release is T0 (PC_out=MAR_in=IncPC=Z_in=1).
//  - IR=0x18918000 (add R1,R2,R3) → T4 Grc Rout Z_in alu=00011; T5 Zlow_out Gra Rin; T0 again 6 cycles after prior T0.
//  - IR=0x9B180019 (brmi R6,25), CON_out=0 → T6 Zlow_out=1 PC_in=0; CON_out=1 → PC_in=1; 7 cycles.
//  - IR=0x01000095 (ld R2,0x95(R0)) → T5 MAR_in, T6 Read MDR_in, T7 MDR_out Gra Rin; 8 cycles. Stop=1 at T7 → HALT.
//  - IR=0xD8000000 (halt) → HALT after T2, Run=0 and outputs 0 for 10 cycles; clr pulse → T0.
//  - IR=0x81880000 (mul R3,R1): with CU_MULDIV_EN → LO_in at T5, HI_in at T6; without → T0 follows T2.

Source files
------------

// File: rtl/mini_src_control_unit_if.sv
// Strobe/status bundle between the Mini SRC control unit and its datapath.
// The control unit connects through the master modport, the datapath through slave.
interface mini_src_control_unit_if #(
  parameter int unsigned OPW = 5
);
  // datapath -> control unit
  logic [31:0]    IR_Data;
  logic           CON_out;
  logic           Stop;

  // control unit -> datapath
  logic           PC_out, PC_in, IncPC;
  logic           MAR_in, MDR_in, MDR_out, Read, Write;
  logic           IR_in, Y_in, Z_in, Zlow_out, Zhigh_out;
  logic           HI_in, HI_out, LO_in, LO_out;
  logic           InPort_out, OutPort_in, C_out;
  logic           Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
  logic [OPW-1:0] alu_instruction_bits;
  logic           Run;

  modport master (
    input  IR_Data, CON_out, Stop,
    output PC_out, PC_in, IncPC,
    output MAR_in, MDR_in, MDR_out, Read, Write,
    output IR_in, Y_in, Z_in, Zlow_out, Zhigh_out,
    output HI_in, HI_out, LO_in, LO_out,
    output InPort_out, OutPort_in, C_out,
    output Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
    output alu_instruction_bits, Run
  );

  modport slave (
    output IR_Data, CON_out, Stop,
    input  PC_out, PC_in, IncPC,
    input  MAR_in, MDR_in, MDR_out, Read, Write,
    input  IR_in, Y_in, Z_in, Zlow_out, Zhigh_out,
    input  HI_in, HI_out, LO_in, LO_out,
    input  InPort_out, OutPort_in, C_out,
    input  Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
    input  alu_instruction_bits, Run
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC CPU: fetch T0-T2, decode the
// opcode, execute T3-T7, repeat. Strobes are registered; the only combinational
// path is the branch PC load in br T6, gated by CON_out.
// Optional feature macro: CU_MULDIV_EN (adds mul/div sequences driving LO/HI).
module mini_src_control_unit #(
  parameter int unsigned OPW = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  mini_src_control_unit_if.master  cu
);

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(8);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(9);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(10);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
  localparam logic [OPW-1:0] OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic           pc_out, pc_in, inc_pc;
    logic           mar_in, mdr_in, mdr_out, read, write;
    logic           ir_in, y_in, z_in, zlow_out, zhigh_out;
    logic           hi_in, hi_out, lo_in, lo_out;
    logic           inport_out, outport_in, c_out;
    logic           gra, grb, grc, rin, rout, baout, con_in;
    logic [OPW-1:0] alu;
  } ctrl_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic           run_q, run_d;

  // Opcode field lives in the top bits of IR; the operand fields are the datapath's business.
  logic [OPW-1:0] ir_op;
  logic           unused_ir;
  assign ir_op     = cu.IR_Data[31 -: OPW];
  assign unused_ir = ^cu.IR_Data[31-OPW:0];

  // Opcodes that run an execute phase (everything else returns to T0 after T2).
  function automatic logic executes(input logic [OPW-1:0] op);
    logic e;
    e = 1'b0;
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT,
      OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: e = 1'b1;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: e = 1'b1;
`endif
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  // Final execute step for each executing opcode.
  function automatic state_t last_step(input logic [OPW-1:0] op);
    state_t s;
    s = S_T3;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: s = S_T5;
      OP_NEG, OP_NOT, OP_JAL:           s = S_T4;
      OP_LD, OP_ST:                     s = S_T7;
      OP_BR:                            s = S_T6;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                   s = S_T6;
`endif
      default:                          s = S_T3;
    endcase
    return s;
  endfunction

  // Sequential successor inside the execute phase.
  function automatic state_t next_seq(input state_t s);
    state_t n;
    case (s)
      S_T3:    n = S_T4;
      S_T4:    n = S_T5;
      S_T5:    n = S_T6;
      S_T6:    n = S_T7;
      default: n = S_T0;
    endcase
    return n;
  endfunction

  // Strobe pattern for a given state and opcode; unlisted steps leave all zero.
  function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      S_T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
          OP_LD, OP_LDI, OP_ST:     begin c.grb = 1'b1; c.baout = 1'b1; c.y_in = 1'b1; end
          OP_NEG, OP_NOT: begin c.grb = 1'b1; c.rout = 1'b1; c.alu = op; c.z_in = 1'b1; end
          OP_BR:   begin c.gra = 1'b1; c.rout = 1'b1; c.con_in = 1'b1; end
          OP_JR:   begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          OP_JAL:  begin c.pc_out = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
          OP_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
          OP_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
`endif
          default: c = '0;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
            begin c.grc = 1'b1; c.rout = 1'b1; c.alu = op; c.z_in = 1'b1; end
          OP_ADDI, OP_LD, OP_LDI, OP_ST:
            begin c.c_out = 1'b1; c.alu = OP_ADD; c.z_in = 1'b1; end
          OP_ANDI: begin c.c_out = 1'b1; c.alu = OP_AND; c.z_in = 1'b1; end
          OP_ORI:  begin c.c_out = 1'b1; c.alu = OP_OR;  c.z_in = 1'b1; end
          OP_NEG, OP_NOT: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_BR:   begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          OP_JAL:  begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin c.grb = 1'b1; c.rout = 1'b1; c.alu = op; c.z_in = 1'b1; end
`endif
          default: c = '0;
        endcase
      end
      S_T5: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
                        begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_LD, OP_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
          OP_BR:        begin c.c_out = 1'b1; c.alu = OP_ADD; c.z_in = 1'b1; end
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
`endif
          default: c = '0;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
          OP_ST: begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
          OP_BR: c.zlow_out = 1'b1;
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
`endif
          default: c = '0;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_ST: c.write = 1'b1;
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state, opcode capture at the T2->T3 boundary, and next-state strobe decode.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        op_d = ir_op;
        if (ir_op == OP_HALT)     state_d = S_HALT;
        else if (executes(ir_op)) state_d = S_T3;
        else                      state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        if (state_q == last_step(op_q)) state_d = cu.Stop ? S_HALT : S_T0;
        else                            state_d = next_seq(state_q);
      end
    endcase
    ctrl_d = decode(state_d, op_d);
    run_d  = (state_d != S_RST) && (state_d != S_HALT);
  end

  // State, latched opcode and registered strobes; clr wins at every edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_RST;
      op_q    <= '0;
      ctrl_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      run_q   <= run_d;
    end
  end

  // Drive the bundle; br T6 loads PC only when the condition flag is set.
  assign cu.PC_out               = ctrl_q.pc_out;
  assign cu.PC_in                = ctrl_q.pc_in |
                                   ((state_q == S_T6) && (op_q == OP_BR) && cu.CON_out);
  assign cu.IncPC                = ctrl_q.inc_pc;
  assign cu.MAR_in               = ctrl_q.mar_in;
  assign cu.MDR_in               = ctrl_q.mdr_in;
  assign cu.MDR_out              = ctrl_q.mdr_out;
  assign cu.Read                 = ctrl_q.read;
  assign cu.Write                = ctrl_q.write;
  assign cu.IR_in                = ctrl_q.ir_in;
  assign cu.Y_in                 = ctrl_q.y_in;
  assign cu.Z_in                 = ctrl_q.z_in;
  assign cu.Zlow_out             = ctrl_q.zlow_out;
  assign cu.Zhigh_out            = ctrl_q.zhigh_out;
  assign cu.HI_in                = ctrl_q.hi_in;
  assign cu.HI_out               = ctrl_q.hi_out;
  assign cu.LO_in                = ctrl_q.lo_in;
  assign cu.LO_out               = ctrl_q.lo_out;
  assign cu.InPort_out           = ctrl_q.inport_out;
  assign cu.OutPort_in           = ctrl_q.outport_in;
  assign cu.C_out                = ctrl_q.c_out;
  assign cu.Gra                  = ctrl_q.gra;
  assign cu.Grb                  = ctrl_q.grb;
  assign cu.Grc                  = ctrl_q.grc;
  assign cu.Rin                  = ctrl_q.rin;
  assign cu.Rout                 = ctrl_q.rout;
  assign cu.BAout                = ctrl_q.baout;
  assign cu.CON_in               = ctrl_q.con_in;
  assign cu.alu_instruction_bits = ctrl_q.alu;
  assign cu.Run                  = run_q;

endmodule

// File: tb/tb_mini_src_control_unit.sv
// Directed bench for mini_src_control_unit: walks reset, fetch, several opcode
// classes, branch gating, Stop/halt, mid-instruction reset and mul/div.
module tb_mini_src_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  mini_src_control_unit_if cu_if ();

  mini_src_control_unit dut (
    .clk (clk),
    .clr (clr),
    .cu  (cu_if)
  );

  always #5 clk = ~clk;

  // Observed strobes, bit n matches the M_* masks below.
  logic [27:0] obs;
  assign obs = {cu_if.Run, cu_if.CON_in, cu_if.BAout, cu_if.Rout, cu_if.Rin,
                cu_if.Grc, cu_if.Grb, cu_if.Gra, cu_if.C_out, cu_if.OutPort_in,
                cu_if.InPort_out, cu_if.LO_out, cu_if.LO_in, cu_if.HI_out,
                cu_if.HI_in, cu_if.Zhigh_out, cu_if.Zlow_out, cu_if.Z_in,
                cu_if.Y_in, cu_if.IR_in, cu_if.Write, cu_if.Read, cu_if.MDR_out,
                cu_if.MDR_in, cu_if.MAR_in, cu_if.IncPC, cu_if.PC_in, cu_if.PC_out};

  localparam logic [27:0] M_PC_OUT   = 28'd1 << 0;
  localparam logic [27:0] M_PC_IN    = 28'd1 << 1;
  localparam logic [27:0] M_INCPC    = 28'd1 << 2;
  localparam logic [27:0] M_MAR_IN   = 28'd1 << 3;
  localparam logic [27:0] M_MDR_IN   = 28'd1 << 4;
  localparam logic [27:0] M_MDR_OUT  = 28'd1 << 5;
  localparam logic [27:0] M_READ     = 28'd1 << 6;
  localparam logic [27:0] M_WRITE    = 28'd1 << 7;
  localparam logic [27:0] M_IR_IN    = 28'd1 << 8;
  localparam logic [27:0] M_Y_IN     = 28'd1 << 9;
  localparam logic [27:0] M_Z_IN     = 28'd1 << 10;
  localparam logic [27:0] M_ZLOW     = 28'd1 << 11;
  localparam logic [27:0] M_ZHIGH    = 28'd1 << 12;
  localparam logic [27:0] M_HI_IN    = 28'd1 << 13;
  localparam logic [27:0] M_HI_OUT   = 28'd1 << 14;
  localparam logic [27:0] M_LO_IN    = 28'd1 << 15;
  localparam logic [27:0] M_LO_OUT   = 28'd1 << 16;
  localparam logic [27:0] M_INPORT   = 28'd1 << 17;
  localparam logic [27:0] M_OUTPORT  = 28'd1 << 18;
  localparam logic [27:0] M_C_OUT    = 28'd1 << 19;
  localparam logic [27:0] M_GRA      = 28'd1 << 20;
  localparam logic [27:0] M_GRB      = 28'd1 << 21;
  localparam logic [27:0] M_GRC      = 28'd1 << 22;
  localparam logic [27:0] M_RIN      = 28'd1 << 23;
  localparam logic [27:0] M_ROUT     = 28'd1 << 24;
  localparam logic [27:0] M_BAOUT    = 28'd1 << 25;
  localparam logic [27:0] M_CON_IN   = 28'd1 << 26;
  localparam logic [27:0] M_RUN      = 28'd1 << 27;

  localparam logic [27:0] M_DRIVERS = M_PC_OUT | M_MDR_OUT | M_ZLOW | M_ZHIGH | M_HI_OUT |
                                      M_LO_OUT | M_INPORT | M_C_OUT | M_ROUT | M_BAOUT;

  localparam logic [27:0] F_T0 = M_PC_OUT | M_MAR_IN | M_INCPC | M_Z_IN;
  localparam logic [27:0] F_T1 = M_ZLOW | M_PC_IN | M_READ | M_MDR_IN;
  localparam logic [27:0] F_T2 = M_MDR_OUT | M_IR_IN;

  // Compare one observed value against its expectation and log a mismatch.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full strobe + ALU code check, plus the one-bus-driver rule.
  task automatic expect_st(input string tag, input logic [27:0] m, input logic [4:0] alu);
    check_val(tag, {31'd0, cu_if.alu_instruction_bits, obs}, {31'd0, alu, m});
    check_val({tag, "_drv"}, 64'($countones(obs & M_DRIVERS) <= 1), 64'd1);
  endtask

  // Executing step: Run is expected high alongside the listed strobes.
  task automatic expect_run(input string tag, input logic [27:0] m, input logic [4:0] alu);
    expect_st(tag, m | M_RUN, alu);
  endtask

  // Steps from T0 through T2 checking the fetch strobes.
  task automatic fetch(input string tag);
    step(); expect_run({tag, "_t1"}, F_T1, 5'd0);
    step(); expect_run({tag, "_t2"}, F_T2, 5'd0);
  endtask

  initial begin
    cu_if.IR_Data = 32'h18918000;
    cu_if.CON_out = 1'b0;
    cu_if.Stop    = 1'b0;

    // Reset held two cycles
    clr = 1'b1;
    step(); step();
    expect_st("rst", 28'd0, 5'd0);
    clr = 1'b0;
    step(); expect_run("add_t0", F_T0, 5'd0);

    // add R1,R2,R3
    fetch("add");
    step(); expect_run("add_t3", M_GRB | M_ROUT | M_Y_IN, 5'd0);
    step(); expect_run("add_t4", M_GRC | M_ROUT | M_Z_IN, 5'b00011);
    step(); expect_run("add_t5", M_ZLOW | M_GRA | M_RIN, 5'd0);
    step(); expect_run("add_next_t0", F_T0, 5'd0);

    // brmi R6,25 with the condition false at T6, then true
    cu_if.IR_Data = 32'h9B180019;
    fetch("br");
    step(); expect_run("br_t3", M_GRA | M_ROUT | M_CON_IN, 5'd0);
    step(); expect_run("br_t4", M_PC_OUT | M_Y_IN, 5'd0);
    step(); expect_run("br_t5", M_C_OUT | M_Z_IN, 5'b00011);
    step(); expect_run("br_t6_con0", M_ZLOW, 5'd0);
    cu_if.CON_out = 1'b1;
    #1; expect_run("br_t6_con1", M_ZLOW | M_PC_IN, 5'd0);
    step(); expect_run("br_next_t0", F_T0, 5'd0);
    cu_if.CON_out = 1'b0;

    // neg: two-step execute
    cu_if.IR_Data = 32'h88800000;
    fetch("neg");
    step(); expect_run("neg_t3", M_GRB | M_ROUT | M_Z_IN, 5'b10001);
    step(); expect_run("neg_t4", M_ZLOW | M_GRA | M_RIN, 5'd0);
    step(); expect_run("neg_next_t0", F_T0, 5'd0);

    // st: shares T3-T5 with ld, then register to MDR and Write
    cu_if.IR_Data = 32'h10800010;
    fetch("st");
    step(); expect_run("st_t3", M_GRB | M_BAOUT | M_Y_IN, 5'd0);
    step(); expect_run("st_t4", M_C_OUT | M_Z_IN, 5'b00011);
    step(); expect_run("st_t5", M_ZLOW | M_MAR_IN, 5'd0);
    step(); expect_run("st_t6", M_GRA | M_ROUT | M_MDR_IN, 5'd0);
    step(); expect_run("st_t7", M_WRITE, 5'd0);
    step(); expect_run("st_next_t0", F_T0, 5'd0);

    // nop and an undefined opcode return to T0 straight after T2
    cu_if.IR_Data = 32'hD0000000;
    fetch("nop");
    step(); expect_run("nop_next_t0", F_T0, 5'd0);
    cu_if.IR_Data = 32'hF8000000;
    fetch("undef");
    step(); expect_run("undef_next_t0", F_T0, 5'd0);

    // ld R2,0x95(R0) with Stop raised in its last step
    cu_if.IR_Data = 32'h01000095;
    fetch("ld");
    step(); expect_run("ld_t3", M_GRB | M_BAOUT | M_Y_IN, 5'd0);
    step(); expect_run("ld_t4", M_C_OUT | M_Z_IN, 5'b00011);
    step(); expect_run("ld_t5", M_ZLOW | M_MAR_IN, 5'd0);
    step(); expect_run("ld_t6", M_READ | M_MDR_IN, 5'd0);
    step(); expect_run("ld_t7", M_MDR_OUT | M_GRA | M_RIN, 5'd0);
    cu_if.Stop = 1'b1;
    step(); expect_st("ld_stop_halt", 28'd0, 5'd0);
    cu_if.Stop = 1'b0;
    step(); expect_st("ld_halt_hold", 28'd0, 5'd0);
    clr = 1'b1;
    step(); expect_st("ld_clr_rst", 28'd0, 5'd0);
    clr = 1'b0;
    step(); expect_run("ld_clr_t0", F_T0, 5'd0);

    // halt opcode: parks in HALT until clr
    cu_if.IR_Data = 32'hD8000000;
    fetch("halt");
    for (int i = 0; i < 10; i++) begin
      step(); expect_st($sformatf("halt_hold_%0d", i), 28'd0, 5'd0);
    end
    clr = 1'b1;
    step(); expect_st("halt_clr_rst", 28'd0, 5'd0);
    clr = 1'b0;
    step(); expect_run("halt_clr_t0", F_T0, 5'd0);

    // Reset in the middle of an add abandons it
    cu_if.IR_Data = 32'h18918000;
    fetch("abort");
    step(); expect_run("abort_t3", M_GRB | M_ROUT | M_Y_IN, 5'd0);
    clr = 1'b1;
    step(); expect_st("abort_rst", 28'd0, 5'd0);
    clr = 1'b0;
    step(); expect_run("abort_t0", F_T0, 5'd0);

    // mul R3,R1
    cu_if.IR_Data = 32'h81880000;
    fetch("mul");
`ifdef CU_MULDIV_EN
    step(); expect_run("mul_t3", M_GRA | M_ROUT | M_Y_IN, 5'd0);
    step(); expect_run("mul_t4", M_GRB | M_ROUT | M_Z_IN, 5'b10000);
    step(); expect_run("mul_t5", M_ZLOW | M_LO_IN, 5'd0);
    step(); expect_run("mul_t6", M_ZHIGH | M_HI_IN, 5'd0);
    step(); expect_run("mul_next_t0", F_T0, 5'd0);
`else
    step(); expect_run("mul_as_nop_t0", F_T0, 5'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
